// File: rtl/gpi_pkg.sv
// Shared types and default constants for the general-purpose input conditioner.
package gpi_pkg;

   // Debounce FSM states, 1-bit encoding
   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } gpi_state_e;

   localparam int unsigned GPI_WIDTH    = 8;
   localparam int unsigned GPI_DEBOUNCE = 250000;

endpackage : gpi_pkg

// File: rtl/gpi_sync.sv
// Two-flop synchronizer for a vector of asynchronous inputs.
module gpi_sync #(
   parameter int unsigned WIDTH = gpi_pkg::GPI_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync1_d, sync1_q;
   logic [WIDTH-1:0] sync2_d, sync2_q;

   // next values: shift the raw pins down the two-stage chain
   always_comb begin
      sync1_d = d;
      sync2_d = sync1_q;
   end

   // synchronizer stages with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign q = sync2_q;

endmodule : gpi_sync

// File: rtl/gpi_debounce.sv
// GPIO input conditioner: synchronizes and debounces the raw pin vector, holds
// the last stable value and flags each committed change with a valid/read
// handshake. Define GPI_IRQ_EN to add the oIRQ commit pulse output.
module gpi_debounce
   import gpi_pkg::*;
#(
   parameter int unsigned WIDTH           = GPI_WIDTH,
   parameter int unsigned DEBOUNCE_CYCLES = GPI_DEBOUNCE,
   parameter int unsigned CNT_W           = 18
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic [WIDTH-1:0] iRAW,
   input  logic             iRD,
   output logic [WIDTH-1:0] oDATA,
   output logic             oVALID,
   output logic [WIDTH-1:0] oCHANGED,
   output logic             oOVERRUN
`ifdef GPI_IRQ_EN
   ,
   output logic             oIRQ
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync2;

   gpi_state_e       state_d, state_q;
   logic [WIDTH-1:0] cand_d, cand_q;
   logic [WIDTH-1:0] stable_d, stable_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             valid_d, valid_q;
   logic [WIDTH-1:0] changed_d, changed_q;
   logic             overrun_d, overrun_q;
   logic             commit;
   logic             rd_fire;

   gpi_sync #(.WIDTH(WIDTH)) u_sync (
      .clk   (iCLK),
      .rst_n (iRST_N),
      .d     (iRAW),
      .q     (sync2)
   );

   assign rd_fire = iRD & valid_q;

   // debounce FSM and valid/read handshake next-state logic
   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      stable_d  = stable_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      changed_d = changed_q;
      overrun_d = overrun_q;
      commit    = 1'b0;

      case (state_q)
         IDLE: begin
            if (sync2 != cand_q) begin
               cand_d  = sync2;
               cnt_d   = '0;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (sync2 != cand_q) begin
               cand_d = sync2;
               cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               // settling back onto the old stable value produces no event
               commit  = (cand_q != stable_q);
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (commit) begin
         stable_d = cand_q;
         valid_d  = 1'b1;
         if (rd_fire) begin
            // a read on the commit edge consumes the older change bits
            changed_d = stable_q ^ cand_q;
            overrun_d = 1'b0;
         end else begin
            changed_d = changed_q | (stable_q ^ cand_q);
            overrun_d = overrun_q | valid_q;
         end
      end else if (rd_fire) begin
         valid_d   = 1'b0;
         changed_d = '0;
         overrun_d = 1'b0;
      end
   end

   // state and handshake registers, synchronous active-low reset
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q   <= IDLE;
         cand_q    <= '0;
         stable_q  <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         changed_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cand_q    <= cand_d;
         stable_q  <= stable_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         changed_q <= changed_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef GPI_IRQ_EN
   logic irq_d, irq_q;

   // one-cycle pulse on every commit edge, independent of oVALID
   always_comb begin
      irq_d = commit;
   end

   // interrupt pulse register
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign oIRQ = irq_q;
`endif

   assign oDATA    = stable_q;
   assign oVALID   = valid_q;
   assign oCHANGED = changed_q;
   assign oOVERRUN = overrun_q;

endmodule : gpi_debounce

// File: tb/tb_gpi_debounce.sv
// Directed testbench for gpi_debounce with WIDTH=8, DEBOUNCE_CYCLES=4.
// Define GPI_IRQ_EN to also check the oIRQ pulse.
module tb_gpi_debounce;

   logic       iCLK = 1'b0;
   logic       iRST_N;
   logic [7:0] iRAW;
   logic       iRD;
   logic [7:0] oDATA;
   logic       oVALID;
   logic [7:0] oCHANGED;
   logic       oOVERRUN;
`ifdef GPI_IRQ_EN
   logic       oIRQ;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;

   gpi_debounce #(
      .WIDTH           (8),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (18)
   ) dut (
      .iCLK     (iCLK),
      .iRST_N   (iRST_N),
      .iRAW     (iRAW),
      .iRD      (iRD),
      .oDATA    (oDATA),
      .oVALID   (oVALID),
      .oCHANGED (oCHANGED),
      .oOVERRUN (oOVERRUN)
`ifdef GPI_IRQ_EN
      ,
      .oIRQ     (oIRQ)
`endif
   );

   always #5 iCLK = ~iCLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // advance one rising edge and settle 1 time unit past it
   task automatic tick(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge iCLK);
         #1;
      end
   endtask

   task automatic do_reset();
      iRST_N = 1'b0;
      iRAW   = 8'h00;
      iRD    = 1'b0;
      tick(2);
      iRST_N = 1'b1;
      tick(2);
   endtask

   task automatic read_pulse();
      iRD = 1'b1;
      tick(1);
      iRD = 1'b0;
   endtask

   task automatic check_irq(input string tag, input logic exp);
`ifdef GPI_IRQ_EN
      check_eq(tag, {31'd0, oIRQ}, {31'd0, exp});
`endif
   endtask

   initial begin
      // reset state
      iRST_N = 1'b0;
      iRAW   = 8'h00;
      iRD    = 1'b0;
      tick(3);
      check_eq("rst_data",    {24'd0, oDATA},    32'h00);
      check_eq("rst_valid",   {31'd0, oVALID},   32'h0);
      check_eq("rst_changed", {24'd0, oCHANGED}, 32'h00);
      check_eq("rst_overrun", {31'd0, oOVERRUN}, 32'h0);
      check_irq("rst_irq", 1'b0);
      iRST_N = 1'b1;
      tick(3);
      check_eq("idle_valid", {31'd0, oVALID}, 32'h0);

      // 0x00 -> 0xA5: first tick is e0, commit visible after e0+6
      iRAW = 8'hA5;
      tick(6);
      check_eq("a5_early_valid", {31'd0, oVALID}, 32'h0);
      check_eq("a5_early_data",  {24'd0, oDATA},  32'h00);
      check_irq("a5_early_irq", 1'b0);
      tick(1);
      check_eq("a5_valid",   {31'd0, oVALID},   32'h1);
      check_eq("a5_data",    {24'd0, oDATA},    32'hA5);
      check_eq("a5_changed", {24'd0, oCHANGED}, 32'hA5);
      check_eq("a5_overrun", {31'd0, oOVERRUN}, 32'h0);
      check_irq("a5_irq", 1'b1);
      read_pulse();
      check_eq("a5_rd_valid",   {31'd0, oVALID},   32'h0);
      check_eq("a5_rd_changed", {24'd0, oCHANGED}, 32'h00);
      check_eq("a5_rd_data",    {24'd0, oDATA},    32'hA5);
      check_irq("a5_irq_after", 1'b0);
      // read with nothing pending is ignored
      read_pulse();
      check_eq("idle_rd_valid", {31'd0, oVALID}, 32'h0);
      check_eq("idle_rd_data",  {24'd0, oDATA},  32'hA5);

      // glitch: 0x01 for 3 cycles then back to 0x00, never committed
      do_reset();
      iRAW = 8'h01;
      tick(3);
      iRAW = 8'h00;
      for (int unsigned i = 0; i < 12; i++) begin
         tick(1);
         check_eq("glitch_valid", {31'd0, oVALID}, 32'h0);
         check_eq("glitch_data",  {24'd0, oDATA},  32'h00);
         check_irq("glitch_irq", 1'b0);
      end

      // two unread commits: 0x00 -> 0x0F -> 0x3F
      do_reset();
      iRAW = 8'h0F;
      tick(7);
      check_eq("c1_valid", {31'd0, oVALID}, 32'h1);
      check_eq("c1_data",  {24'd0, oDATA},  32'h0F);
      iRAW = 8'h3F;
      tick(7);
      check_eq("c2_valid",   {31'd0, oVALID},   32'h1);
      check_eq("c2_data",    {24'd0, oDATA},    32'h3F);
      check_eq("c2_changed", {24'd0, oCHANGED}, 32'h3F);
      check_eq("c2_overrun", {31'd0, oOVERRUN}, 32'h1);
      check_irq("c2_irq", 1'b1);
      read_pulse();
      check_eq("c2_rd_valid",   {31'd0, oVALID},   32'h0);
      check_eq("c2_rd_changed", {24'd0, oCHANGED}, 32'h00);
      check_eq("c2_rd_overrun", {31'd0, oOVERRUN}, 32'h0);

      // read on the same edge as a commit: 0x0F pending, then 0x8F
      do_reset();
      iRAW = 8'h0F;
      tick(7);
      check_eq("rc1_valid", {31'd0, oVALID}, 32'h1);
      iRAW = 8'h8F;
      tick(6);
      check_eq("rc_pre_data",  {24'd0, oDATA},  32'h0F);
      check_eq("rc_pre_valid", {31'd0, oVALID}, 32'h1);
      iRD = 1'b1;
      tick(1);
      iRD = 1'b0;
      check_eq("rc_valid",   {31'd0, oVALID},   32'h1);
      check_eq("rc_data",    {24'd0, oDATA},    32'h8F);
      check_eq("rc_changed", {24'd0, oCHANGED}, 32'h80);
      check_eq("rc_overrun", {31'd0, oOVERRUN}, 32'h0);
      check_irq("rc_irq", 1'b1);

      // reset mid-settle (cnt=2) with 0x55 held
      iRAW = 8'h55;
      tick(5);
      iRST_N = 1'b0;
      tick(1);
      check_eq("mrst_data",    {24'd0, oDATA},    32'h00);
      check_eq("mrst_valid",   {31'd0, oVALID},   32'h0);
      check_eq("mrst_changed", {24'd0, oCHANGED}, 32'h00);
      check_eq("mrst_overrun", {31'd0, oOVERRUN}, 32'h0);
      iRST_N = 1'b1;
      tick(6);
      check_eq("mrst_early_valid", {31'd0, oVALID}, 32'h0);
      tick(1);
      check_eq("mrst_valid2",   {31'd0, oVALID},   32'h1);
      check_eq("mrst_data2",    {24'd0, oDATA},    32'h55);
      check_eq("mrst_changed2", {24'd0, oCHANGED}, 32'h55);
      check_eq("mrst_overrun2", {31'd0, oOVERRUN}, 32'h0);
      check_irq("mrst_irq", 1'b1);
      tick(1);
      check_irq("mrst_irq_after", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_gpi_debounce

// File: doc/gpi_debounce.md
Name: gpi_debounce

Overview:
- Input-side GPIO conditioner between the board switches/keys and the core's general-purpose input bus.
- Synchronizes the raw asynchronous pins and debounces them as one vector.
- Holds the last stable value on oDATA and flags each committed change to the core with a valid/read handshake.
- Complements the core's GPO output path: the core polls oVALID, reads oDATA and oCHANGED, then strobes iRD.

Parameters:
- WIDTH, 8, number of input bits.
- DEBOUNCE_CYCLES, 250000, iCLK cycles the synchronized vector must stay unchanged before it is committed; legal range 2 to 2^CNT_W-1.
- CNT_W, 18, debounce counter width.

Ports:
- iCLK  in  1  system clock, all logic on its rising edge.
- iRST_N  in  1  synchronous active-low reset, sampled on the rising edge of iCLK.
- iRAW  in  WIDTH  raw asynchronous pin inputs (SW/KEY).
- iRD  in  1  core read strobe; one cycle wide; meaningful only while oVALID=1.
- oDATA  out  WIDTH  last committed (stable) input vector.
- oVALID  out  1  an unread commit is pending.
- oCHANGED  out  WIDTH  OR of (old XOR new) across all commits since the last read.
- oOVERRUN  out  1  a commit occurred while oVALID was already 1 and no iRD was present that cycle.

Behaviour:
- Reset (iRST_N=0 at an edge):
  - sync1, sync2, candidate, stable/oDATA, and cnt go to 0.
  - oVALID, oCHANGED, and oOVERRUN go to 0.
  - State goes to IDLE.
  - A non-zero iRAW held through reset yields one commit after release.
  - Reset mid-settle discards the candidate.
- Synchronizer: two flops per bit (iRAW -> sync1 -> sync2). No metastability logic beyond that.
- State IDLE (candidate == stable):
  - If sync2 != candidate: candidate <= sync2, cnt <= 0, go to SETTLE.
- State SETTLE:
  - If sync2 != candidate: candidate <= sync2, cnt <= 0, stay in SETTLE (glitch restart).
  - Else if cnt == DEBOUNCE_CYCLES-1:
    - Commit if candidate != stable: stable <= candidate; this is a commit event.
    - Go to IDLE.
  - Else cnt <= cnt+1.
  - If the input returns to the old stable value and settles, the block returns to IDLE with no event.
- Latency: if e0 is the first edge at which sync1 captures a new iRAW value held steadily, oVALID/oDATA update at edge e0+DEBOUNCE_CYCLES+2.
- Commit event:
  - oDATA <= candidate.
  - oVALID <= 1.
  - oCHANGED <= oCHANGED | (stable ^ candidate).
  - oOVERRUN <= 1 if oVALID was already 1.
- Read (iRD=1 and oVALID=1, no commit in the same cycle): oVALID, oCHANGED, and oOVERRUN clear at the next edge.
- Read with oVALID=0: ignored.
- Simultaneous read and commit, commit wins:
  - oVALID stays 1.
  - oCHANGED = stable ^ candidate only; prior bits are considered consumed.
  - oOVERRUN <= 0.
- The counter never wraps; it is reset on every sync2 change.

Optional Feature:
- GPI_IRQ_EN defined: adds output oIRQ (1 bit, reset 0), a single-cycle pulse at every commit edge regardless of oVALID. The core can use it as an interrupt or wake source.
- Undefined: the oIRQ port and its logic are absent; the core polls oVALID.

Decomposition:
- Package gpi_pkg holds:
  - state enum {IDLE, SETTLE}, 1-bit encoding;
  - default constants GPI_WIDTH=8 and GPI_DEBOUNCE=250000.
- Sub-module gpi_sync: parameterized WIDTH two-flop synchronizer with synchronous active-low reset, instantiated once.
- Debounce FSM, counter, and handshake registers stay in gpi_debounce.

Test Plan (WIDTH=8, DEBOUNCE_CYCLES=4):
- Reset, iRAW=0x00, release, iRAW 0x00->0xA5 at e0:
  - oVALID rises at e0+6 with oDATA=0xA5, oCHANGED=0xA5, oOVERRUN=0.
  - iRD one cycle later clears oVALID and oCHANGED.
- Glitch: iRAW 0x00->0x01 for 3 cycles, then back to 0x00: oVALID stays 0 and oDATA stays 0x00 throughout.
- Two unread commits, 0x00->0x0F, then after settle 0x0F->0x3F:
  - oDATA=0x3F, oCHANGED=0x3F, oOVERRUN=1.
  - iRD clears all three flags.
- iRD asserted on the same edge as a second commit (0x0F->0x8F): oVALID stays 1, oCHANGED=0x80, oOVERRUN=0.
- iRST_N low for one cycle at cnt=2 during SETTLE, with iRAW=0x55 held:
  - All outputs go to 0.
  - After release, oVALID rises 6 edges after the first post-reset sampling edge, with oDATA=0x55.
- With GPI_IRQ_EN defined, every commit above gives exactly one oIRQ pulse coincident with the oDATA update. Compiled without it, the netlist has no oIRQ port.
